sha256_msg_schedule: RTL and testbench

- Producer side of the round datapath's w/k interface. Supplies the (W_t, K_t) pairs that the SHA-256 compression round consumes, one pair per round, t = 0..63.
- Accepts one 512-bit padded message block through a valid/ready handshake. Expands it into 64 schedule words on the fly using a 16-word sliding window.
- Presents each word with its round constant and index through a second valid/ready handshake, so the round controller can stall it.

---
 rtl/sha256_pkg.sv | 39 +++
 rtl/sha256_k_rom.sv | 11 +
 rtl/sha256_msg_schedule.sv | 111 +++++++++++
 tb/tb_sha256_msg_schedule.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, small-sigma helpers and the
// message-schedule state encoding.
package sha256_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_e;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Small sigmas used by the message expansion; rotations are written as
    // explicit bit concatenations so no width promotion can creep in.
    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational SHA-256 round-constant ROM, indexed by round number.
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0]  addr,
    output logic [31:0] data
);

    assign data = K[addr];

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads a 512-bit block and streams (W_t, K_t, t)
// for t = 0..63 through a stallable valid/ready interface.
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_out,
    output logic [31:0]  k_out,
    output logic [5:0]   round,
    output logic         done
);

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    sched_state_e      state_q, state_d;
    logic [15:0][31:0] window_q, window_d;
    logic [5:0]        round_q, round_d;
    logic              blk_ready_q, blk_ready_d;
    logic              w_valid_q, w_valid_d;
    logic              done_q, done_d;
    logic [31:0]       new_word;

    // Next schedule word entering the top of the window; the same recurrence
    // is valid for every t because window[0..15] always holds W_t..W_t+15.
    assign new_word = sigma1(window_q[14]) + window_q[9] + sigma0(window_q[1]) + window_q[0];

    always_comb begin
        state_d     = state_q;
        window_d    = window_q;
        round_d     = round_q;
        blk_ready_d = blk_ready_q;
        w_valid_d   = w_valid_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                blk_ready_d = 1'b1;
                w_valid_d   = 1'b0;
                if (blk_ready_q && blk_valid) begin
                    for (int i = 0; i < 16; i++) begin
                        window_d[i] = blk_data[511 - 32*i -: 32];
                    end
                    round_d     = 6'd0;
                    state_d     = RUN;
                    blk_ready_d = 1'b0;
                    w_valid_d   = 1'b1;
                end
            end
            RUN: begin
                if (w_ready) begin
                    for (int i = 0; i < 15; i++) begin
                        window_d[i] = window_q[i + 1];
                    end
                    window_d[15] = new_word;
                    round_d      = round_q + 6'd1;
                    // Ready goes high together with done so a waiting block
                    // can be accepted without an extra bubble.
                    if (round_q == LAST_ROUND) begin
                        state_d     = IDLE;
                        done_d      = 1'b1;
                        blk_ready_d = 1'b1;
                        w_valid_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                blk_ready_d = 1'b1;
                w_valid_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            window_q    <= '0;
            round_q     <= 6'd0;
            blk_ready_q <= 1'b0;
            w_valid_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            window_q    <= window_d;
            round_q     <= round_d;
            blk_ready_q <= blk_ready_d;
            w_valid_q   <= w_valid_d;
            done_q      <= done_d;
        end
    end

    sha256_k_rom u_k_rom (
        .addr (round_q),
        .data (k_out)
    );

    assign w_out     = window_q[0];
    assign round     = round_q;
    assign blk_ready = blk_ready_q;
    assign w_valid   = w_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Scoreboard bench for sha256_msg_schedule: a FIPS-style reference model
// fills an expected queue per block, a negedge monitor drains it.
module tb_sha256_msg_schedule;

    typedef struct {
        logic [31:0] w;
        logic [31:0] k;
        logic [5:0]  r;
        bit          last;
    } exp_item_t;

    localparam logic [31:0] KTAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [511:0] ABC_BLOCK = {32'h61626380, {14{32'h00000000}}, 32'h00000018};

    logic         clk = 1'b0;
    logic         rst;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_out;
    logic [31:0]  k_out;
    logic [5:0]   round;
    logic         done;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_item_t   sb[$];
    bit          mon_en   = 1'b0;
    bit          exp_done = 1'b0;
    int          rdy_mode = 2;
    int          xfer_cnt = 0;
    int          push_cnt = 0;
    logic [31:0] log_w [64];
    logic [31:0] log_k [64];

    sha256_msg_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_out     (w_out),
        .k_out     (k_out),
        .round     (round),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference model helpers, written straight from the FIPS 180-4 definitions.
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pushModel(input logic [511:0] blk);
        logic [31:0] w [64];
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
        for (int t = 0; t < 64; t++) sb.push_back('{w[t], KTAB[t], 6'(t), (t == 63)});
        push_cnt += 64;
    endtask

    function automatic logic [511:0] randomBlock();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
        return b;
    endfunction

    // Offers a block and returns once it has been accepted; accDone reports
    // whether acceptance happened during a done pulse.
    task automatic applyStimulus(input logic [511:0] data, output bit accDone);
        int n = 0;
        accDone   = 1'b0;
        blk_valid = 1'b1;
        blk_data  = data;
        forever begin
            @(negedge clk);
            if (blk_ready === 1'b1) break;
            n++;
            if (n > 3000) begin
                checkOutput("accept_timeout", 32'(blk_ready), 32'd1);
                blk_valid = 1'b0;
                return;
            end
        end
        accDone = done;
        @(posedge clk);
        pushModel(data);
        #1 blk_valid = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checkOutput({name, "_drain_timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput({name, "_xfer_count"}, 32'(xfer_cnt), 32'(push_cnt));
    endtask

    task automatic waitRound(input int r, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (w_valid === 1'b1 && round === 6'(r)) begin
                ok = 1'b1;
                return;
            end
        end
        checkOutput("wait_round_timeout", 32'(round), 32'(r));
    endtask

    task automatic clearLog();
        for (int i = 0; i < 64; i++) begin
            log_w[i] = '0;
            log_k[i] = '0;
        end
    endtask

    task automatic checkAbcLog(input string name);
        checkOutput({name, "_w0"},  log_w[0],  32'h61626380);
        checkOutput({name, "_k0"},  log_k[0],  32'h428a2f98);
        checkOutput({name, "_w16"}, log_w[16], 32'h61626380);
        checkOutput({name, "_w17"}, log_w[17], 32'h000f0000);
        checkOutput({name, "_w63"}, log_w[63], 32'h12b1edeb);
        checkOutput({name, "_k63"}, log_k[63], 32'hc67178f2);
    endtask

    // Monitor: compares every presented pair against the queue head and pops
    // it only when the consumer accepts, so stalls must hold the same pair.
    initial begin
        exp_item_t e;
        forever begin
            @(negedge clk);
            if (mon_en && rst === 1'b1) begin
                checkOutput("done", 32'(done), 32'(exp_done));
                exp_done = 1'b0;
                checkOutput("blk_ready", 32'(blk_ready), 32'(!w_valid));
                if (w_valid === 1'b1) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_word", 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb[0];
                        checkOutput("w_out", w_out, e.w);
                        checkOutput("k_out", k_out, e.k);
                        checkOutput("round", 32'(round), 32'(e.r));
                        if (w_ready === 1'b1) begin
                            void'(sb.pop_front());
                            xfer_cnt++;
                            log_w[e.r] = w_out;
                            log_k[e.r] = k_out;
                            if (e.last) exp_done = 1'b1;
                        end
                    end
                end else if (sb.size() != 0) begin
                    checkOutput("w_valid_latency", 32'(w_valid), 32'd1);
                end
            end
        end
    end

    // Consumer-side ready driver: 0 = always ready, 1 = random, 2 = manual.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) w_ready = 1'b1;
            else if (rdy_mode == 1) w_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc;
        bit ok;
        rst       = 1'b0;
        blk_valid = 1'b0;
        blk_data  = '0;
        w_ready   = 1'b0;
        clearLog();

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_blk_ready", 32'(blk_ready), 32'd1);
        checkOutput("reset_w_valid", 32'(w_valid), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_w_out", w_out, 32'd0);
        checkOutput("reset_round", 32'(round), 32'd0);
        checkOutput("reset_k_out", k_out, 32'h428a2f98);
        mon_en = 1'b1;

        // "abc" block, always ready
        $display("[TB] abc block, w_ready tied high");
        rdy_mode = 0;
        applyStimulus(ABC_BLOCK, acc);
        waitIdle("abc");
        checkAbcLog("abc");

        // Stall at round 17 for five cycles
        $display("[TB] stall at round 17");
        clearLog();
        rdy_mode = 2;
        w_ready  = 1'b1;
        applyStimulus(ABC_BLOCK, acc);
        waitRound(17, ok);
        w_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("stall_round", 32'(round), 32'd17);
            checkOutput("stall_w_out", w_out, 32'h000f0000);
        end
        w_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("stall_release_round", 32'(round), 32'd18);
        checkOutput("stall_release_valid", 32'(w_valid), 32'd1);
        rdy_mode = 0;
        waitIdle("stall");
        checkOutput("stall_w63", log_w[63], 32'h12b1edeb);

        // Random blocks with random back-pressure
        $display("[TB] random blocks");
        rdy_mode = 1;
        for (int b = 0; b < 3; b++) begin
            applyStimulus(randomBlock(), acc);
            waitIdle("random");
        end

        // Back-to-back blocks: the second is offered while the first runs
        $display("[TB] back-to-back blocks");
        applyStimulus(randomBlock(), acc);
        applyStimulus(randomBlock(), acc);
        checkOutput("b2b_accept_in_done", 32'(acc), 32'd1);
        waitIdle("b2b");

        // blk_valid during RUN must be ignored
        $display("[TB] ignored block during run");
        clearLog();
        rdy_mode = 0;
        applyStimulus(ABC_BLOCK, acc);
        blk_valid = 1'b1;
        blk_data  = randomBlock();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("run_blk_ready", 32'(blk_ready), 32'd0);
        blk_valid = 1'b0;
        waitIdle("ignored");
        checkAbcLog("ignored");

        // Reset in the middle of a block
        $display("[TB] reset mid-block");
        applyStimulus(ABC_BLOCK, acc);
        waitRound(30, ok);
        mon_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst_w_valid", 32'(w_valid), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_round", 32'(round), 32'd0);
        checkOutput("midrst_w_out", w_out, 32'd0);
        sb.delete();
        exp_done = 1'b0;
        push_cnt = xfer_cnt;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_blk_ready", 32'(blk_ready), 32'd1);
        checkOutput("midrst_done_after", 32'(done), 32'd0);
        mon_en = 1'b1;
        clearLog();
        applyStimulus(ABC_BLOCK, acc);
        waitIdle("post_reset");
        checkAbcLog("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
